// File: rtl/mul_seq_ctrl.sv
// Sequential multiplier controller: forms a*b by repeated addition on a shared combinational
// ALU, alternating ADD (accumulate) and DEC (count down) cycles with sticky overflow/error flags.
module mul_seq_ctrl #(
  parameter int unsigned N      = 4,
  parameter logic [3:0]  ADD_OP = 4'b0000,
  parameter logic [3:0]  SUB_OP = 4'b0001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product,
  output logic         ovf,
  output logic         err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_out,
  input  logic         alu_of,
  input  logic         alu_zero,
  input  logic         alu_err
);

  typedef enum logic [2:0] {StIdle, StLoad, StAdd, StDec, StDone} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] a_reg_q, a_reg_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] product_q, product_d;
  logic         ovf_q, ovf_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_op_q, alu_op_d;

  always_comb begin
    state_d   = state_q;
    a_reg_d   = a_reg_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_reg_d   = a;
          cnt_d     = b;
          acc_d     = '0;
          product_d = '0;
          ovf_d     = 1'b0;
          err_d     = 1'b0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        state_d = (cnt_q == '0) ? StDone : StAdd;
      end
      StAdd: begin
        if (alu_err) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          acc_d   = alu_out;
          ovf_d   = ovf_q | alu_of;
          state_d = StDec;
        end
      end
      StDec: begin
        if (alu_err) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d   = alu_out;
          state_d = alu_zero ? StDone : StAdd;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Result is latched on entry to DONE so it stays put until the next accepted start.
    if (state_d == StDone) begin
      product_d = acc_d;
    end

    // Outputs are registered: decode them from the state being entered.
    busy_d   = (state_d == StAdd) || (state_d == StDec);
    done_d   = (state_d == StDone);
    alu_a_d  = '0;
    alu_b_d  = '0;
    alu_op_d = ADD_OP;
    if (state_d == StAdd) begin
      alu_a_d = acc_d;
      alu_b_d = a_reg_d;
    end else if (state_d == StDec) begin
      alu_a_d  = cnt_d;
      alu_b_d  = N'(1);
      alu_op_d = SUB_OP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_reg_q   <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= ADD_OP;
    end else begin
      state_q   <= state_d;
      a_reg_q   <= a_reg_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign ovf     = ovf_q;
  assign err     = err_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: a small combinational ALU model closes the loop and each
// operation is checked for latency, busy length, product and flags against hand-computed values.
module tb_mul_seq_ctrl;

  localparam int unsigned N      = 4;
  localparam logic [3:0]  ADD_OP = 4'b0000;
  localparam logic [3:0]  SUB_OP = 4'b0001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, ovf, err;
  logic [N-1:0] product, alu_a, alu_b, alu_out;
  logic [3:0]   alu_op;
  logic         alu_of, alu_zero;
  logic         alu_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(
    .N      (N),
    .ADD_OP (ADD_OP),
    .SUB_OP (SUB_OP)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .ovf      (ovf),
    .err      (err),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_of   (alu_of),
    .alu_zero (alu_zero),
    .alu_err  (alu_err)
  );

  // ALU model: N-bit add with carry-out, subtract with borrow.
  logic [N:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    if (alu_op == SUB_OP) alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
    else                  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
  end
  assign alu_out  = alu_wide[N-1:0];
  assign alu_of   = alu_wide[N];
  assign alu_zero = (alu_wide[N-1:0] == '0);

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and follows the run. done_cyc is the edge count after which done was seen
  // (-1 on timeout). glitch_cyc injects a start with other operands; err_cyc forces alu_err.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input int glitch_cyc,
                        input int err_cyc, output int done_cyc, output int busy_cnt);
    int c;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    tick();
    start    = 1'b0;
    done_cyc = -1;
    busy_cnt = 0;
    c        = 0;
    while (c < 100) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        break;
      end
      start   = (c == glitch_cyc);
      a       = (c == glitch_cyc) ? 4'd3 : ta;
      b       = (c == glitch_cyc) ? 4'd1 : tb_v;
      alu_err = (c == err_cyc);
      tick();
      c++;
    end
    start   = 1'b0;
    alu_err = 1'b0;
  endtask

  initial begin
    int dc, bc, extra_busy, extra_done;

    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, ADD_OP);
    rst = 1'b0;
    tick();

    run_op(4'd4, 4'd3, -1, -1, dc, bc);
    check("4x3_done_cyc", dc, 7);
    check("4x3_busy_cyc", bc, 6);
    check("4x3_product", product, 12);
    check("4x3_ovf", ovf, 0);
    check("4x3_err", err, 0);
    tick();
    check("4x3_done_pulse", done, 0);

    run_op(4'd5, 4'd4, -1, -1, dc, bc);
    check("5x4_done_cyc", dc, 9);
    check("5x4_product", product, 4);
    check("5x4_ovf", ovf, 1);
    tick();
    tick();
    tick();
    check("5x4_product_held", product, 4);
    check("5x4_ovf_held", ovf, 1);
    run_op(4'd2, 4'd2, -1, -1, dc, bc);
    check("2x2_done_cyc", dc, 5);
    check("2x2_product", product, 4);
    check("2x2_ovf", ovf, 0);
    tick();

    run_op(4'd7, 4'd0, -1, -1, dc, bc);
    check("7x0_done_cyc", dc, 1);
    check("7x0_busy_cyc", bc, 0);
    check("7x0_product", product, 0);
    tick();
    run_op(4'd0, 4'd5, -1, -1, dc, bc);
    check("0x5_done_cyc", dc, 11);
    check("0x5_product", product, 0);
    check("0x5_ovf", ovf, 0);
    tick();

    run_op(4'd15, 4'd15, 10, -1, dc, bc);
    check("15x15_done_cyc", dc, 31);
    check("15x15_busy_cyc", bc, 30);
    check("15x15_product", product, 1);
    check("15x15_ovf", ovf, 1);
    extra_busy = 0;
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy) extra_busy++;
      if (done) extra_done++;
    end
    check("15x15_no_rerun_busy", extra_busy, 0);
    check("15x15_no_rerun_done", extra_done, 0);
    check("15x15_product_held", product, 1);

    // Reset lands at edge 4 of a 3x5 run.
    start = 1'b1;
    a     = 4'd3;
    b     = 4'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_product", product, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_op", alu_op, ADD_OP);
    rst = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) extra_done++;
    end
    check("mid_rst_no_activity", extra_done, 0);
    run_op(4'd3, 4'd5, -1, -1, dc, bc);
    check("3x5_done_cyc", dc, 11);
    check("3x5_product", product, 15);
    check("3x5_ovf", ovf, 0);
    tick();

    // Second ADD of 2x3 is the cycle after edge 3.
    run_op(4'd2, 4'd3, -1, 3, dc, bc);
    check("err_done_cyc", dc, 4);
    check("err_flag", err, 1);
    check("err_product", product, 2);
    tick();
    tick();
    check("err_held", err, 1);
    run_op(4'd1, 4'd1, -1, -1, dc, bc);
    check("err_cleared", err, 0);
    check("1x1_product", product, 1);
    check("1x1_done_cyc", dc, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
